// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter and bus sequencer that lets one of three
// requesters (fetch, load, store) run one memory transaction at a time.
// The FSM walks IDLE -> GRANT -> ADDR -> WAIT -> RELEASE -> DONE -> IDLE.
// If mfc never arrives, or never drops, it goes to ERROR instead.
// Every output is a register that is loaded on the edge entering a state.
// The done pulse is the one exception: it is loaded when DONE is left, so
// it appears in the following IDLE cycle. That IDLE cycle also arbitrates,
// and it masks out the requester that has just finished.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   req      in   [2] fetch, [1] load, [0] store access request
//   req_rw   in   per-requester direction, 1 = read, 0 = write
//   mfc      in   memory function complete
//   err_clr  in   leaves ERROR (ignored elsewhere)
//   gnt      out  one-hot grant
//   done     out  one-hot single-cycle completion pulse
//   en       out  memory enable
//   rw       out  memory direction, 1 = read
//   mar_oe   out  MAR drives address
//   mdr_we   out  MDR captures read data
//   mdr_oe   out  MDR drives write data
//   err      out  memory timeout flag
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [2:0] req_rw,
  input  logic       mfc,
  input  logic       err_clr,
  output logic [2:0] gnt,
  output logic [2:0] done,
  output logic       en,
  output logic       rw,
  output logic       mar_oe,
  output logic       mdr_we,
  output logic       mdr_oe,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_ADDR, S_WAIT, S_RELEASE, S_DONE, S_ERROR
  } state_e;

  localparam logic [3:0] TIMEOUT_L = 4'(TIMEOUT);

  state_e     state_q;
  logic [1:0] last_q;     // last winner; also the index of the active transaction
  logic [3:0] cnt_q;
  logic [2:0] gnt_q;
  logic [2:0] done_q;
  logic       en_q, rw_q, mar_oe_q, mdr_we_q, mdr_oe_q, err_q;

  logic [3:0]      cnt_d;
  logic [2:0]      masked_d;
  logic [2:0][1:0] order_d;    // order_d[0] has the highest priority
  logic            pick_vld_d;
  logic [1:0]      pick_idx_d;

  always_comb begin
    cnt_d    = cnt_q + 4'd1;
    // A requester whose done pulse is showing must not win again in this cycle.
    masked_d = req & ~done_q;
    // Descending order, starting just below the last winner and wrapping.
    case (last_q)
      2'd0:    order_d = {2'd0, 2'd1, 2'd2};
      2'd1:    order_d = {2'd1, 2'd2, 2'd0};
      default: order_d = {2'd2, 2'd0, 2'd1};
    endcase
    pick_vld_d = 1'b0;
    pick_idx_d = 2'd0;
    // Walk from lowest to highest priority, so the highest-priority hit is written last.
    for (int i = 2; i >= 0; i--) begin
      if (masked_d[order_d[i]]) begin
        pick_vld_d = 1'b1;
        pick_idx_d = order_d[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      last_q   <= 2'd0;
      cnt_q    <= 4'd0;
      gnt_q    <= 3'b000;
      done_q   <= 3'b000;
      en_q     <= 1'b0;
      rw_q     <= 1'b0;
      mar_oe_q <= 1'b0;
      mdr_we_q <= 1'b0;
      mdr_oe_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 3'b000;
      case (state_q)
        S_IDLE: begin
          if (pick_vld_d) begin
            state_q <= S_GRANT;
            last_q  <= pick_idx_d;
            gnt_q   <= 3'b001 << pick_idx_d;
            rw_q    <= req_rw[pick_idx_d];
          end
        end
        S_GRANT: begin
          state_q  <= S_ADDR;
          en_q     <= 1'b1;
          mar_oe_q <= 1'b1;
          mdr_oe_q <= ~rw_q;
        end
        S_ADDR: begin
          state_q  <= S_WAIT;
          cnt_q    <= 4'd0;
          mdr_we_q <= rw_q;
        end
        S_WAIT: begin
          // mfc is tested first, so it beats a timeout that lands on the same edge.
          if (mfc) begin
            state_q  <= S_RELEASE;
            cnt_q    <= 4'd0;
            en_q     <= 1'b0;
            mar_oe_q <= 1'b0;
            mdr_we_q <= 1'b0;
            mdr_oe_q <= 1'b0;
          end else if (cnt_d == TIMEOUT_L) begin
            state_q  <= S_ERROR;
            cnt_q    <= cnt_d;
            gnt_q    <= 3'b000;
            en_q     <= 1'b0;
            rw_q     <= 1'b0;
            mar_oe_q <= 1'b0;
            mdr_we_q <= 1'b0;
            mdr_oe_q <= 1'b0;
            err_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_RELEASE: begin
          if (!mfc) begin
            state_q <= S_DONE;
            gnt_q   <= 3'b000;
            rw_q    <= 1'b0;
          end else if (cnt_d == TIMEOUT_L) begin
            state_q <= S_ERROR;
            cnt_q   <= cnt_d;
            gnt_q   <= 3'b000;
            rw_q    <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 3'b001 << last_q;
        end
        S_ERROR: begin
          if (err_clr) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign en     = en_q;
  assign rw     = rw_q;
  assign mar_oe = mar_oe_q;
  assign mdr_we = mdr_we_q;
  assign mdr_oe = mdr_oe_q;
  assign err    = err_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 12, SHALL set the maximum number of cycles spent in WAIT or RELEASE before error (range 1-15).
REQ-002 clk  input  1  single system clock; all state SHALL change on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req  input  3  memory-access requests, one bit per requester: bit2 fetch FSM, bit1 load FSM, bit0 store FSM.
REQ-005 req_rw  input  3  per-requester direction: 1 = read from memory, 0 = write to memory.
REQ-006 mfc  input  1  memory-function-complete from memory.
REQ-007 err_clr  input  1  clears the ERROR state.
REQ-008 gnt  output  3  one-hot grant, same bit order as req.
REQ-009 done  output  3  one-hot, one-cycle completion pulse to the granted requester.
REQ-010 en  output  1  memory enable.
REQ-011 rw  output  1  memory direction: 1 = read, 0 = write.
REQ-012 mar_oe  output  1  MAR drives the memory address.
REQ-013 mdr_we  output  1  MDR captures memory data (reads only).
REQ-014 mdr_oe  output  1  MDR drives memory data (writes only).
REQ-015 err  output  1  memory timeout flag.

Function
REQ-016 All outputs SHALL be registered Moore outputs of a state machine with states IDLE, GRANT, ADDR, WAIT, RELEASE, DONE, ERROR.
REQ-017 IDLE: all outputs 0 except done; a nonzero masked req selects a winner, and the next state is GRANT.
REQ-018 Arbitration: round-robin, descending index with wrap, starting below the last winner (last=0 -> order 2,1,0; last=2 -> 1,0,2); the last-winner pointer updates on GRANT entry.
REQ-019 Mask: in the cycle done[i]=1, req[i] SHALL be excluded from arbitration.
REQ-020 GRANT, one cycle: gnt[winner]=1; req_rw[winner] is latched into rw; the requester loads MAR this cycle; next state ADDR.
REQ-021 ADDR, one cycle: gnt held; en=1; mar_oe=1; mdr_oe=1 if rw=0; next state WAIT; timeout counter cleared.
REQ-022 WAIT: en, mar_oe and mdr_oe held; mdr_we=1 if rw=1.
REQ-023 WAIT exit: mfc=1 -> RELEASE with the counter cleared; else the counter increments, and counter==TIMEOUT -> ERROR.
REQ-024 WAIT tie-break: if mfc=1 and timeout coincide, mfc SHALL win.
REQ-025 RELEASE: en, mar_oe, mdr_we and mdr_oe are 0; gnt held; stay while mfc=1 (counter increments, TIMEOUT -> ERROR); mfc=0 -> DONE.
REQ-026 DONE, one cycle: gnt=0; done[winner]=1; next state IDLE, which arbitrates in that IDLE cycle under the REQ-019 mask.
REQ-027 Once GRANT is entered, the transaction SHALL complete irrespective of req changes; deasserting req does not abort it.
REQ-028 ERROR: err=1; gnt=0; en=0; all enables 0; no done pulse; err_clr=1 -> IDLE next cycle, and err_clr is ignored in all other states.
REQ-029 gnt SHALL never have more than one bit set; en=1 SHALL only occur with exactly one gnt bit set.
REQ-030 Latency: req sampled in IDLE at edge n gives gnt at n+1, en at n+2, and done at the second edge after mfc falls. Minimum transaction is 6 cycles from req to done.

Reset
REQ-031 rst=1 SHALL immediately force IDLE and all outputs to 0, including err.
REQ-032 On reset, the counter SHALL be 0 and the last-winner pointer SHALL be 0, so fetch has first priority.
REQ-033 Reset mid-transaction SHALL abandon the transaction without a done pulse.

Verification
REQ-034 Reset, then req=3'b111 held with mfc returned 2 cycles after en -> grants in order fetch, load, store, fetch (gnt 100, 010, 001, 100); each done matches the preceding gnt.
REQ-035 Single read: req=3'b100, req_rw=3'b100, mfc high 3 cycles after en -> rw=1, mdr_we=1 in WAIT, mdr_oe=0; done=3'b100 exactly once; req held high re-grants fetch only after the masked DONE cycle.
REQ-036 Single write by store: req=3'b001, req_rw=0 -> mdr_oe=1 from ADDR through WAIT, mdr_we never 1, rw=0.
REQ-037 Timeout: mfc held 0 -> err=1 exactly TIMEOUT(12) cycles after WAIT entry; gnt=0, en=0; err_clr pulse -> IDLE, err=0, new request served.
REQ-038 mfc asserted in the same cycle the counter reaches TIMEOUT -> RELEASE, no err; rst asserted during WAIT -> all outputs 0 asynchronously, no done, next grant goes to fetch.
